// File: rtl/quadra_pkg.sv
// quadra_pkg: shared definitions for the quadra evaluator and its result FIFO.
//   Y_W            - width of a quadra result
//   y_t            - quadra result type
//   QUADRA_LAT     - falling edges from x sampled to y stable
//   RES_FIFO_DEPTH - entries in the downstream result FIFO
//   level_t        - FIFO occupancy count, 0..RES_FIFO_DEPTH inclusive
package quadra_pkg;

    localparam int Y_W            = 23;
    localparam int QUADRA_LAT     = 3;
    localparam int RES_FIFO_DEPTH = 8;
    localparam int LEVEL_W        = $clog2(RES_FIFO_DEPTH) + 1;

    typedef logic [Y_W-1:0]     y_t;
    typedef logic [LEVEL_W-1:0] level_t;

endpackage

// File: rtl/quadra_valid_delay.sv
// quadra_valid_delay: LAT-deep shift register that follows each accepted
// sample through quadra's pipeline.
//   clk      - clock, state updates on the falling edge
//   rst_b    - synchronous active-low reset, clears every stage
//   accept   - a sample entered quadra at this edge
//   vlast    - the result emerging from quadra this cycle is real
//   inflight - number of real samples currently inside quadra
module quadra_valid_delay
    import quadra_pkg::*;
#(
    parameter int LAT  = QUADRA_LAT,
    parameter int CW   = $clog2(LAT + 1)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          accept,
    output logic          vlast,
    output logic [CW-1:0] inflight
);

    logic [LAT-1:0] vpipe;

    always_ff @(negedge clk) begin
        if (!rst_b) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(vpipe[i]);
        end
    end

    assign vlast = vpipe[LAT-1];

endmodule

// File: rtl/quadra_result_fifo.sv
// quadra_result_fifo: captures quadra results for accepted samples into a
// first-word-fall-through FIFO. quadra cannot stall, so upstream is held
// off by credit: a sample is only accepted when every result already
// stored or still in flight has a guaranteed FIFO slot.
//   clk       - clock, all state updates on the falling edge
//   rst_b     - synchronous active-low reset
//   in_valid  - x presented to quadra this cycle is a real sample
//   in_ready  - a sample can be accepted this cycle
//   y         - quadra result
//   out_valid - out_y holds the oldest stored result
//   out_y     - head of FIFO
//   out_ready - consumer takes the head at this edge
//   level     - stored entries
//   err_drop  - sticky, in_valid was seen while in_ready was low
module quadra_result_fifo
#(
    parameter int Y_W   = quadra_pkg::Y_W,
    parameter int LAT   = quadra_pkg::QUADRA_LAT,
    parameter int DEPTH = quadra_pkg::RES_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [Y_W-1:0]           y,
    output logic                     out_valid,
    output logic [Y_W-1:0]           out_y,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_drop
);

    import quadra_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(LAT + 1);
    localparam int SW = LW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [Y_W-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  inflight;
    logic [SW-1:0]  credit_sum;
    logic           accept;
    logic           wr_en;
    logic           pop;

    // Credit counts results still inside quadra as if already stored.
    assign credit_sum = SW'(level) + SW'(inflight);
    assign in_ready   = credit_sum < SW'(DEPTH);
    assign accept     = in_valid && in_ready;

    assign out_valid  = (level != '0);
    assign out_y      = mem[rd_ptr];
    assign pop        = out_valid && out_ready;

    quadra_valid_delay #(
        .LAT (LAT),
        .CW  (CW)
    ) u_valid_delay (
        .clk      (clk),
        .rst_b    (rst_b),
        .accept   (accept),
        .vlast    (wr_en),
        .inflight (inflight)
    );

    // Storage is not reset; out_y is only meaningful while out_valid is high.
    always_ff @(negedge clk) begin
        if (rst_b && wr_en) begin
            mem[wr_ptr] <= y;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_b) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            err_drop <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(wr_en) - LW'(pop);
            if (in_valid && !in_ready) begin
                err_drop <= 1'b1;
            end
        end
    end

    level_in_range: assert property (@(negedge clk) disable iff (!rst_b) level <= DEPTH_L);

endmodule
